rep_add_mul: RTL and testbench
==============================

Name: rep_add_mul

Overview:
- Sequential 32-bit multiplier that computes a product by repeated addition.
- Loads operands A and B, adds A into an accumulator while a down-counter (initialised from B) is non-zero, and uses an equal-zero flag (eqz) to terminate.
- This is the consumer side of the team's zero-detect/masking datapath: it generates and acts on the eqz condition rather than masking with it.
- Sits behind a start/done handshake so a controller or testbench can issue one multiply at a time.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  multiplicand, sampled with start.
- b_in  input  WIDTH  multiplier (iteration count), sampled with start.
- busy  output  1  high in ADD and DONE states.
- done  output  1  one-cycle pulse when the product is valid.
- eqz  output  1  high when the down-counter equals 0.
- product  output  2*WIDTH  result; held stable until the next accepted start.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; A, B counter and product = 0.
  - busy=0, done=0, eqz=1.
- States: IDLE, ADD, DONE. Encoding is free; all outputs are registered or decoded from state only.
- IDLE:
  - If start=1 at the edge: A<=a_in, cnt<=b_in, product<=0, go to ADD.
  - Otherwise hold; product keeps its last result.
- ADD:
  - If cnt!=0: product<=product+zero-extended A, cnt<=cnt-1, stay in ADD.
  - If cnt==0: go to DONE; product unchanged.
- DONE:
  - done=1 for exactly this one cycle, then go to IDLE unconditionally.
- Latency:
  - The start edge is edge 0. There are b_in+1 ADD cycles, so done is high in the cycle after edge b_in+2.
  - b_in=0 gives done after edge 2 with product=0.
- Arithmetic:
  - Accumulator is 2*WIDTH wide; A is zero-extended. No overflow is possible, since the max is (2^W-1)^2.
  - Operands are unsigned.
- eqz = (cnt==0), combinational from the counter register. It is 1 in IDLE after reset.
- Boundary conditions:
  - start while busy=1 is ignored; no re-load, no queueing.
  - start held high continuously: a new operation is accepted on the first IDLE cycle after DONE, i.e. back-to-back with one IDLE cycle gap.
  - a_in/b_in changing after acceptance has no effect.
  - a_in=0 with large b_in still iterates b_in times; product stays 0.
  - rst_n asserted mid-operation aborts immediately to reset values. No done pulse is generated for the aborted operation.

Optional Feature:
- Macro: REP_ADD_MUL_SWAP_EN.
- Defined:
  - On acceptance, if b_in > a_in, operands are swapped (A<=b_in, cnt<=a_in), so the iteration count is min(a_in,b_in).
  - Latency becomes min(a_in,b_in)+2; product is unchanged.
  - The comparator adds no extra cycle.
- Undefined:
  - No comparator; the count is always b_in, as described above.

Test Plan:
- Reset, then a_in=3, b_in=4, start pulse -> busy=1 next cycle; eqz=0 during ADD; done pulses one cycle after edge 6; product=12; busy=0 afterwards.
- a_in=7, b_in=0 -> done after edge 2, product=0, eqz stays 1 throughout.
- a_in=0xFFFFFFFF, b_in=2 -> product=0x00000001_FFFFFFFE, done after edge 4.
- a_in=5, b_in=3 accepted; then start pulsed with a_in=9, b_in=9 while busy -> ignored; product=15; the next start from IDLE with 9,9 gives 81.
- a_in=6, b_in=10 started; rst_n low at edge 5 -> outputs zero immediately, no done; after release, a 2*3 run gives 6.
- With REP_ADD_MUL_SWAP_EN: a_in=2, b_in=1000 -> done after edge 4, product=2000. Without the macro, the same stimulus gives done after edge 1002.

Source files
------------

// File: rtl/rep_add_mul.sv
// ---------------------------------------------------------------------------
// rep_add_mul
//
// Sequential unsigned multiplier built from repeated addition. On an accepted
// start the multiplicand is latched into A and the multiplier into a
// down-counter. Each ADD cycle with a non-zero counter adds zero-extended A
// into a 2*WIDTH accumulator and decrements the counter. The equal-zero flag
// (eqz) ends the loop; a one-cycle done pulse follows.
//
// Optional build macro: REP_ADD_MUL_SWAP_EN
//   When defined, the larger operand becomes A and the smaller one becomes
//   the iteration count, so the loop runs min(a_in, b_in) times. The compare
//   is folded into the acceptance cycle and costs no extra latency.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   a_in     in   [WIDTH-1:0]   multiplicand, sampled with start
//   b_in     in   [WIDTH-1:0]   multiplier / iteration count, sampled with start
//   busy     out  high in ADD and DONE
//   done     out  one-cycle pulse when product is valid
//   eqz      out  high when the down-counter is zero
//   product  out  [2*WIDTH-1:0] result, held until the next accepted start
// ---------------------------------------------------------------------------
module rep_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic               eqz,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Operand selection at acceptance time.
  logic [WIDTH-1:0]     load_a;
  logic [WIDTH-1:0]     load_cnt;

`ifdef REP_ADD_MUL_SWAP_EN
  // Iterate over the smaller operand; the product is commutative.
  always_comb begin
    load_a   = a_in;
    load_cnt = b_in;
    if (b_in > a_in) begin
      load_a   = b_in;
      load_cnt = a_in;
    end
  end
`else
  always_comb begin
    load_a   = a_in;
    load_cnt = b_in;
  end
`endif

  // The loop terminates on the counter register, so eqz is also the
  // ADD-state exit condition.
  assign eqz = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d       = load_a;
          cnt_d     = load_cnt;
          product_d = '0;
          state_d   = ST_ADD;
        end
      end
      ST_ADD: begin
        if (!eqz) begin
          product_d = product_q + {{WIDTH{1'b0}}, a_q};
          cnt_d     = cnt_q - WIDTH'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // start is ignored here; a held start is taken on the next IDLE cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Status outputs decode directly from the state register.
  assign busy    = (state_q == ST_ADD) || (state_q == ST_DONE);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_rep_add_mul.sv
module tb_rep_add_mul;

  localparam int WIDTH = 32;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               done;
  logic               eqz;
  logic [2*WIDTH-1:0] product;

  int checks;
  int failures;

  rep_add_mul #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .eqz     (eqz),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] exp_product;
    int                 lat_plain;  // edge index of done, counted from the start edge
    int                 lat_swap;   // same, with operand swap enabled
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input vec_t v);
`ifdef REP_ADD_MUL_SWAP_EN
    return v.lat_swap;
`else
    return v.lat_plain;
`endif
  endfunction

  // Start edge = edge 0 (start driven just after it, sampled at edge 1).
  task automatic run(input string name, input vec_t v);
    int  edges;
    int  lat;
    bit  cnt_zero;
    bit  eqz_dropped;
    lat = exp_lat(v);
    cnt_zero = (lat == 2);
    eqz_dropped = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a_in = v.a; b_in = v.b;
    edges = 0;
    @(posedge clk); edges = 1; #1;
    start = 1'b0;
    a_in = 32'hDEAD_BEEF; b_in = 32'h0000_0077;  // post-acceptance changes must not matter
    chk({name, "_busy_after_accept"}, {63'd0, busy}, 64'd1);
    chk({name, "_eqz_first_add"}, {63'd0, eqz}, {63'd0, cnt_zero});
    while (done !== 1'b1 && edges < lat + 20) begin
      if (eqz !== 1'b1) eqz_dropped = 1'b1;
      @(posedge clk); edges++; #1;
    end
    chk({name, "_done_seen"}, {63'd0, done}, 64'd1);
    chk({name, "_latency"}, 64'(edges), 64'(lat));
    chk({name, "_product"}, product, v.exp_product);
    if (cnt_zero) chk({name, "_eqz_held_high"}, {63'd0, eqz_dropped}, 64'd0);
    @(posedge clk); #1;
    chk({name, "_done_pulse_end"}, {63'd0, done}, 64'd0);
    chk({name, "_busy_after"}, {63'd0, busy}, 64'd0);
    chk({name, "_product_hold"}, product, v.exp_product);
    $display("run %s a=0x%0h b=0x%0h product=0x%0h edges=%0d", name, v.a, v.b, product, edges);
  endtask

  task automatic wait_done(input string name, input int max_cycles, output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < max_cycles) begin
      @(posedge clk); edges++; #1;
    end
    chk({name, "_done_seen"}, {63'd0, done}, 64'd1);
  endtask

  initial begin
    int    e;
    vec_t  v;
    checks = 0;
    failures = 0;

    vecs[0] = '{a: 32'd3,          b: 32'd4,    exp_product: 64'd12,                 lat_plain: 6,    lat_swap: 5};
    vecs[1] = '{a: 32'd7,          b: 32'd0,    exp_product: 64'd0,                  lat_plain: 2,    lat_swap: 2};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'd2,    exp_product: 64'h0000_0001_FFFF_FFFE, lat_plain: 4,   lat_swap: 4};
    vecs[3] = '{a: 32'd0,          b: 32'd20,   exp_product: 64'd0,                  lat_plain: 22,   lat_swap: 2};
    vecs[4] = '{a: 32'd2,          b: 32'd1000, exp_product: 64'd2000,               lat_plain: 1002, lat_swap: 4};
    vecs[5] = '{a: 32'd9,          b: 32'd9,    exp_product: 64'd81,                 lat_plain: 11,   lat_swap: 11};
    vecs[6] = '{a: 32'd1,          b: 32'd1,    exp_product: 64'd1,                  lat_plain: 3,    lat_swap: 3};
    vecs[7] = '{a: 32'd100,        b: 32'd3,    exp_product: 64'd300,                lat_plain: 5,    lat_swap: 5};

    // Reset state
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    #12;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_eqz", {63'd0, eqz}, 64'd1);
    chk("reset_product", product, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    $display("reset released busy=%0b done=%0b eqz=%0b product=0x%0h", busy, done, eqz, product);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run($sformatf("vec%0d", i), vecs[i]);
    end

    // Start while busy is ignored
    @(posedge clk); #1;
    start = 1'b1; a_in = 32'd5; b_in = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a_in = 32'd9; b_in = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_ignore", 40, e);
    chk("busy_ignore_product", product, 64'd15);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_ignore_no_requeue", {63'd0, busy}, 64'd0);
    chk("busy_ignore_product_hold", product, 64'd15);
    $display("busy_ignore product=0x%0h", product);
    v = '{a: 32'd9, b: 32'd9, exp_product: 64'd81, lat_plain: 11, lat_swap: 11};
    run("after_ignore", v);

    // Start held high: one IDLE gap between back-to-back operations
    @(posedge clk); #1;
    start = 1'b1; a_in = 32'd2; b_in = 32'd3;
    wait_done("held_first", 40, e);
    chk("held_first_product", product, 64'd6);
    @(posedge clk); #1;
    chk("held_idle_gap_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk("held_reaccept_busy", {63'd0, busy}, 64'd1);
    chk("held_reaccept_clear", product, 64'd0);
    start = 1'b0;
    wait_done("held_second", 40, e);
    chk("held_second_product", product, 64'd6);
    $display("held_start second product=0x%0h", product);

    // Asynchronous reset mid-operation
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; a_in = 32'd6; b_in = 32'd10;   // edge 0 was the previous posedge
    @(posedge clk); #1;                          // edge 1: accepted
    start = 1'b0;
    repeat (4) @(posedge clk);                   // edge 5
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_eqz", {63'd0, eqz}, 64'd1);
    chk("abort_product", product, 64'd0);
    e = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done === 1'b1) e++;
    end
    chk("abort_no_done", 64'(e), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    $display("abort product=0x%0h busy=%0b", product, busy);
    v = '{a: 32'd2, b: 32'd3, exp_product: 64'd6, lat_plain: 5, lat_swap: 4};
    run("after_abort", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
